std_nbdcache_vldrty_sweeper: RTL

Sequencer that drives the request side of the nbdcache valid/dirty SRAM for bulk maintenance. After reset it zero-initialises every word. On a flush request it reads every word, emits one write-back request per valid-and-dirty way, then clears the word. It sits beside the cache controller, and the controller muxes the SRAM port to this block whenever `busy_o` is high.

---
 rtl/std_nbdcache_vldrty_sweeper.sv | 138 +++++++++++++
 1 files changed

// File: rtl/std_nbdcache_vldrty_sweeper.sv
// rtl/std_nbdcache_vldrty_sweeper.sv - valid/dirty SRAM init and flush sequencer
// Zeroes every set after reset; on flush, reads each set, requests write-back of valid+dirty ways, then clears it.
module std_nbdcache_vldrty_sweeper #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned DataWidth = 2 * NumWays,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  parameter int unsigned WayWidth  = (NumWays > 1) ? $clog2(NumWays) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  output logic                 flush_done_o,
  output logic                 busy_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [AddrWidth-1:0] wb_set_o,
  output logic [WayWidth-1:0]  wb_way_o
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_EVAL,
    S_WB,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_t               r_state;
  logic [AddrWidth-1:0] r_cnt;
  logic [NumWays-1:0]   r_mask;

  logic                 w_last;
  logic [NumWays-1:0]   w_rd_mask;
  logic [NumWays-1:0]   w_low_oh;
  logic [NumWays-1:0]   w_mask_next;
  logic [WayWidth-1:0]  w_way;
  logic                 w_write;
  logic                 w_read;

  assign w_last = (r_cnt == LastAddr);

  always_comb begin
    w_rd_mask = '0;
    for (int w = 0; w < int'(NumWays); w++) begin
      w_rd_mask[w] = sram_rdata_i[2*w] & sram_rdata_i[2*w+1];
    end
  end

  // Lowest pending way: isolate the least significant set bit of the mask.
  assign w_low_oh    = r_mask & (~r_mask + NumWays'(1));
  assign w_mask_next = r_mask & ~w_low_oh;

  always_comb begin
    w_way = '0;
    for (int i = int'(NumWays) - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_way = WayWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (flush_req_i) begin
            r_cnt   <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_EVAL;
        S_EVAL: begin
          r_mask  <= w_rd_mask;
          r_state <= (w_rd_mask != '0) ? S_WB : S_CLEAR;
        end
        S_WB: begin
          if (wb_ready_i) begin
            r_mask <= w_mask_next;
            if (w_mask_next == '0) begin
              r_state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign w_write = (r_state == S_INIT) || (r_state == S_CLEAR);
  assign w_read  = (r_state == S_READ);

  // Request-type outputs are masked by rst_i so nothing leaks while reset is held.
  assign busy_o       = (r_state != S_IDLE);
  assign sram_req_o   = (w_write | w_read) & ~rst_i;
  assign sram_we_o    = w_write;
  assign sram_addr_o  = (w_write | w_read) ? r_cnt : '0;
  assign sram_wdata_o = '0;
  assign sram_be_o    = w_write ? '1 : '0;
  assign wb_valid_o   = (r_state == S_WB) & ~rst_i;
  assign wb_set_o     = r_cnt;
  assign wb_way_o     = w_way;
  assign flush_done_o = (r_state == S_DONE) & ~rst_i;

endmodule
